// File: rtl/int_pkg.sv
// int_pkg: shared constants and FSM encoding for the interrupt responder
package int_pkg;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_7F20;
    localparam logic [1:0]  OFS_ACK   = 2'd0;
    localparam logic [1:0]  OFS_PEND  = 2'd1;
    localparam logic [1:0]  OFS_MASK  = 2'd2;
    localparam logic [1:0]  OFS_TOTAL = 2'd3;
    typedef enum logic [1:0] {IDLE, ASSERT, HOLD} state_t;
endpackage

// File: rtl/int_responder_if.sv
// int_responder_if: system-bridge load/store port of the interrupt responder window
interface int_responder_if;
    logic [31:0] m_int_addr;
    logic [3:0]  m_int_byteen;
    logic [31:0] m_int_wdata;
    logic        m_int_rd;
    logic [31:0] m_int_rdata;
    modport master (output m_int_addr, m_int_byteen, m_int_wdata, m_int_rd, input m_int_rdata);
    modport slave  (input m_int_addr, m_int_byteen, m_int_wdata, m_int_rd, output m_int_rdata);
endinterface

// File: rtl/int_edge_sync.sv
// int_edge_sync: optional 2-flop synchronizer (macro INT_SYNC_EN) plus rising-edge detect
module int_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_interrupt,
    output logic o_req
);
    logic w_in;
    logic r_int_q;
`ifdef INT_SYNC_EN
    logic [1:0] r_sync;
    // two-flop synchronizer so asynchronous interrupt sources are safe
    always_ff @(posedge clk or negedge reset)
        if (!reset) r_sync <= '0;
        else        r_sync <= {r_sync[0], i_interrupt};
    assign w_in = r_sync[1];
`else
    assign w_in = i_interrupt;
`endif
    // remember the previous level so a rising edge yields a one-cycle request
    always_ff @(posedge clk or negedge reset)
        if (!reset) r_int_q <= 1'b0;
        else        r_int_q <= w_in;
    assign o_req = w_in & ~r_int_q;
endmodule

// File: rtl/int_responder.sv
// int_responder: queued external-interrupt responder with ACK/PEND/MASK/TOTAL window (macro INT_SYNC_EN)
module int_responder
    import int_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int          PEND_W    = 4,
    parameter int          HOLDOFF   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            interrupt,
    int_responder_if.slave  bus,
    output logic            irq_req,
    output logic            int_ack
);
    localparam int HW = $clog2(HOLDOFF + 1);

    logic [PEND_W-1:0] r_pend;
    logic              r_ovf;
    logic              r_mask;
    logic [31:0]       r_total;
    logic              r_ack;
    logic [31:0]       r_rdata;
    state_t            r_state;
    logic [HW-1:0]     r_hold;

    logic              w_req;
    logic [31:0]       w_ofs;
    logic              w_hit;
    logic              w_wr;
    logic [1:0]        w_idx;
    logic              w_ack_hit;
    logic              w_full;
    logic              w_inc;
    logic              w_dec;
    logic [PEND_W-1:0] w_pend_next;
    logic              w_mask_next;
    logic [31:0]       w_total_next;
    logic [31:0]       w_rdata;
    state_t            w_state_next;
    logic [HW-1:0]     w_hold_next;
    logic              w_unused;

    int_edge_sync u_edge (
        .clk         (clk),
        .reset       (reset),
        .i_interrupt (interrupt),
        .o_req       (w_req)
    );

    // decode: offset from base covers any word-aligned base, window is 16 bytes
    assign w_ofs     = bus.m_int_addr - BASE_ADDR;
    assign w_hit     = (w_ofs[31:4] == '0);
    assign w_idx     = w_ofs[3:2];
    assign w_wr      = w_hit & (|bus.m_int_byteen);
    assign w_ack_hit = w_wr & (w_idx == OFS_ACK) & (r_pend != '0);
    assign w_full    = &r_pend;
    assign w_inc     = w_req & ~w_ack_hit;
    assign w_dec     = w_ack_hit & ~w_req;
    assign w_pend_next  = (w_inc & ~w_full) ? r_pend + 1'b1 : w_dec ? r_pend - 1'b1 : r_pend;
    assign w_mask_next  = (w_wr & (w_idx == OFS_MASK) & bus.m_int_byteen[0]) ? bus.m_int_wdata[0] : r_mask;
    assign w_total_next = (w_wr & (w_idx == OFS_TOTAL)) ? '0 : r_total + {31'b0, w_req};
    assign w_unused     = ^{bus.m_int_wdata[31:1], w_ofs[1:0]};

    // read mux; ACK and out-of-window reads return zero
    always_comb begin
        w_rdata = '0;
        if (bus.m_int_rd && w_hit)
            case (w_idx)
                OFS_PEND:  w_rdata = 32'({r_ovf, r_pend});
                OFS_MASK:  w_rdata = {31'b0, r_mask};
                OFS_TOTAL: w_rdata = r_total;
                default:   w_rdata = '0;
            endcase
    end

    // request queue, mask, edge total, ack pulse and registered read data
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_pend  <= '0;
            r_ovf   <= 1'b0;
            r_mask  <= 1'b1;
            r_total <= '0;
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_pend  <= w_pend_next;
            r_ovf   <= r_ovf | (w_inc & w_full);
            r_mask  <= w_mask_next;
            r_total <= w_total_next;
            r_ack   <= w_ack_hit;
            r_rdata <= w_rdata;
        end

    // FSM next state: HOLD keeps IRQ low for HOLDOFF cycles so the CPU pipeline drains
    always_comb begin
        w_state_next = r_state;
        w_hold_next  = r_hold;
        case (r_state)
            IDLE:
                if (w_pend_next != '0 && w_mask_next) w_state_next = ASSERT;
            ASSERT:
                if (w_ack_hit) begin
                    w_state_next = HOLD;
                    w_hold_next  = '0;
                end else if (!w_mask_next) w_state_next = IDLE;
            HOLD:
                if (r_hold == HW'(HOLDOFF - 1))
                    w_state_next = (w_pend_next != '0 && w_mask_next) ? ASSERT : IDLE;
                else
                    w_hold_next = r_hold + 1'b1;
            default:
                w_state_next = IDLE;
        endcase
    end

    // FSM state and holdoff counter registers
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_state <= IDLE;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_next;
            r_hold  <= w_hold_next;
        end

    assign irq_req         = (r_state == ASSERT);
    assign int_ack         = r_ack;
    assign bus.m_int_rdata = r_rdata;
endmodule

// File: tb/tb_int_responder.sv
// tb_int_responder: directed self-checking bench for int_responder (default build, INT_SYNC_EN undefined)
module tb_int_responder;
    localparam logic [31:0] A_ACK   = 32'h7F20;
    localparam logic [31:0] A_PEND  = 32'h7F24;
    localparam logic [31:0] A_MASK  = 32'h7F28;
    localparam logic [31:0] A_TOTAL = 32'h7F2C;
    localparam logic [31:0] A_OUT   = 32'h7F30;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic interrupt = 1'b0;
    logic irq_req;
    logic int_ack;
    int   n_err = 0;
    int   n_chk = 0;
    logic [31:0] rd;

    int_responder_if bus ();

    int_responder dut (
        .clk       (clk),
        .reset     (reset),
        .interrupt (interrupt),
        .bus       (bus),
        .irq_req   (irq_req),
        .int_ack   (int_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.m_int_addr = a;
        bus.m_int_wdata = d;
        bus.m_int_byteen = be;
        step();
        bus.m_int_byteen = 4'h0;
    endtask

    task automatic lw(input logic [31:0] a, output logic [31:0] d);
        bus.m_int_addr = a;
        bus.m_int_rd = 1'b1;
        step();
        bus.m_int_rd = 1'b0;
        d = bus.m_int_rdata;
    endtask

    task automatic edge_in();
        interrupt = 1'b1;
        step();
        interrupt = 1'b0;
    endtask

    initial begin
        bus.m_int_addr = '0;
        bus.m_int_wdata = '0;
        bus.m_int_byteen = '0;
        bus.m_int_rd = 1'b0;
        repeat (2) step();
        chk("rst_irq", {31'b0, irq_req}, 0);
        chk("rst_ack", {31'b0, int_ack}, 0);
        chk("rst_rdata", bus.m_int_rdata, 0);
        reset = 1'b1;
        step();
        lw(A_MASK, rd);  chk("rst_mask", rd, 1);
        lw(A_PEND, rd);  chk("rst_pend", rd, 0);
        lw(A_TOTAL, rd); chk("rst_total", rd, 0);

        // single edge, then ack
        edge_in();
        chk("t1_irq_up", {31'b0, irq_req}, 1);
        chk("t1_ack_low", {31'b0, int_ack}, 0);
        repeat (3) step();
        sw(A_ACK, 32'h1, 4'b0001);
        chk("t1_irq_down", {31'b0, irq_req}, 0);
        chk("t1_int_ack", {31'b0, int_ack}, 1);
        step();
        chk("t1_ack_pulse", {31'b0, int_ack}, 0);
        repeat (3) step();
        chk("t1_irq_stays0", {31'b0, irq_req}, 0);
        sw(A_ACK, 32'h1, 4'b1000);
        chk("t1_ack_at_zero", {31'b0, int_ack}, 0);

        // three queued edges, three acks
        for (int i = 0; i < 3; i++) begin
            edge_in();
            step();
        end
        lw(A_PEND, rd); chk("t2_pend3", rd, 3);
        for (int i = 0; i < 3; i++) begin
            chk("t2_irq_before", {31'b0, irq_req}, 1);
            sw(A_ACK, 32'h0, 4'b0010);
            chk("t2_irq_low", {31'b0, irq_req}, 0);
            chk("t2_int_ack", {31'b0, int_ack}, 1);
            step();
            chk("t2_hold", {31'b0, irq_req}, 0);
            step();
            chk("t2_after_hold", {31'b0, irq_req}, (i < 2) ? 1 : 0);
            step();
        end
        lw(A_PEND, rd); chk("t2_pend0", rd, 0);

        // edge and ack in the same cycle with pend=1
        edge_in();
        step();
        interrupt = 1'b1;
        bus.m_int_addr = A_ACK;
        bus.m_int_byteen = 4'hF;
        step();
        interrupt = 1'b0;
        bus.m_int_byteen = 4'h0;
        chk("t3_int_ack", {31'b0, int_ack}, 1);
        chk("t3_irq_low", {31'b0, irq_req}, 0);
        lw(A_PEND, rd);
        chk("t3_pend1", rd, 1);
        chk("t3_irq_hold", {31'b0, irq_req}, 0);
        step();
        chk("t3_irq_back", {31'b0, irq_req}, 1);
        sw(A_ACK, 32'h0, 4'b0001);
        repeat (3) step();
        chk("t3_irq_idle", {31'b0, irq_req}, 0);
        lw(A_TOTAL, rd); chk("t3_total6", rd, 6);
        sw(A_OUT, 32'h0, 4'hF);
        lw(A_TOTAL, rd); chk("out_wr_noeffect", rd, 6);
        lw(A_OUT, rd);   chk("out_rd_zero", rd, 0);
        lw(A_ACK, rd);   chk("ack_rd_zero", rd, 0);
        sw(A_TOTAL, 32'hFFFF_FFFF, 4'b0100);
        lw(A_TOTAL, rd); chk("total_clr", rd, 0);

        // saturation at PEND_W=4
        for (int i = 0; i < 16; i++) begin
            edge_in();
            step();
        end
        lw(A_PEND, rd);  chk("t4_pend_ovf", rd, 32'h1F);
        lw(A_TOTAL, rd); chk("t4_total16", rd, 16);
        chk("t4_irq", {31'b0, irq_req}, 1);

        // reset mid-operation
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        edge_in();
        step();
        edge_in();
        step();
        chk("t6_irq_pre", {31'b0, irq_req}, 1);
        lw(A_PEND, rd); chk("t6_pend2", rd, 2);
        reset = 1'b0;
        #1;
        chk("t6_irq_rst", {31'b0, irq_req}, 0);
        chk("t6_ack_rst", {31'b0, int_ack}, 0);
        chk("t6_rdata_rst", bus.m_int_rdata, 0);
        step();
        reset = 1'b1;
        step();
        lw(A_MASK, rd); chk("t6_mask1", rd, 1);
        lw(A_PEND, rd); chk("t6_pend0", rd, 0);

        // masking
        sw(A_MASK, 32'h0, 4'b0001);
        lw(A_MASK, rd); chk("t5_mask0", rd, 0);
        edge_in();
        chk("t5_irq_masked", {31'b0, irq_req}, 0);
        step();
        chk("t5_irq_masked2", {31'b0, irq_req}, 0);
        lw(A_PEND, rd); chk("t5_pend1", rd, 1);
        sw(A_MASK, 32'h1, 4'b1110);
        chk("t5_mask_be_ignored", {31'b0, irq_req}, 0);
        sw(A_MASK, 32'h1, 4'b0001);
        chk("t5_irq_enabled", {31'b0, irq_req}, 1);
        sw(A_MASK, 32'h0, 4'b0001);
        chk("t5_irq_masked_off", {31'b0, irq_req}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
